// File: rtl/mips_pkg.sv
// Shared encodings for the load/store stage: access sizes, completion codes,
// FSM states and the byte-lane helpers used when driving the memory bus.
package mips_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE    = 2'b00,
    SZ_HALF    = 2'b01,
    SZ_WORD    = 2'b10,
    SZ_ILLEGAL = 2'b11
  } sizeT;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_MISALIGN = 2'b01,
    ERR_ILLEGAL  = 2'b10,
    ERR_TIMEOUT  = 2'b11
  } errT;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    DONE   = 2'b10
  } stateT;

  // Little-endian byte enables for an access of size sz at byte offset a.
  function automatic logic [3:0] laneEnable(input logic [1:0] sz, input logic [1:0] a);
    case (sz)
      SZ_BYTE: return 4'b0001 << a;
      SZ_HALF: return 4'b0011 << a;
      default: return 4'b1111;
    endcase
  endfunction

  // Store data replicated across all lanes so the byte enables pick the target.
  function automatic logic [31:0] storeLanes(input logic [1:0] sz, input logic [31:0] sd);
    case (sz)
      SZ_BYTE: return {4{sd[7:0]}};
      SZ_HALF: return {2{sd[15:0]}};
      default: return sd;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// Selects the addressed lane of a read word and sign- or zero-extends it.
module load_align
  import mips_pkg::*;
(
  input  logic [31:0] rData,
  input  logic [1:0]  addrLo,
  input  logic [1:0]  size,
  input  logic        unsignedLoad,
  output logic [31:0] data
);

  logic [31:0] shifted;

  // Shift the addressed lane down to bit 0, then extend to 32 bits.
  always_comb begin
    shifted = rData >> {addrLo, 3'b000};
    data    = rData;
    case (size)
      SZ_BYTE: data = unsignedLoad ? {24'h000000, shifted[7:0]}
                                   : {{24{shifted[7]}}, shifted[7:0]};
      SZ_HALF: data = unsignedLoad ? {16'h0000, shifted[15:0]}
                                   : {{16{shifted[15]}}, shifted[15:0]};
      default: data = rData;
    endcase
  end

endmodule

// File: rtl/memory_access.sv
// MEM stage: validates a load/store command, runs one memory handshake with a
// bounded wait, aligns load data into the MDR and reports a completion code.
module memory_access
  import mips_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [1:0]  size,
  input  logic        unsignedLoad,
  input  logic [31:0] ALUResult,
  input  logic [31:0] storeData,
  output logic        memReq,
  output logic        memWE,
  output logic [31:0] memAddr,
  output logic [3:0]  memBE,
  output logic [31:0] memWData,
  input  logic        memAck,
  input  logic [31:0] memRData,
  output logic [31:0] readData,
  output logic [31:0] ALUOut,
  output logic        done,
  output logic        busy,
  output logic [1:0]  errCode
);

  localparam int unsigned CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT_CYCLES - 1);

  stateT         state, nextState;
  errT           nextErr;
  logic          opRead, opWrite, loadUns;
  logic [1:0]    sizeR;
  logic [31:0]   sdR;
  logic [CW-1:0] waitCnt;
  logic [31:0]   loadValue;
  logic          misaligned;

  load_align uAlign (
    .rData       (memRData),
    .addrLo      (ALUOut[1:0]),
    .size        (sizeR),
    .unsignedLoad(loadUns),
    .data        (loadValue)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  // Next state and completion code; command checks use the live inputs in IDLE.
  always_comb begin
    nextState  = state;
    nextErr    = ERR_NONE;
    misaligned = (size == SZ_HALF && ALUResult[0]) ||
                 (size == SZ_WORD && ALUResult[1:0] != 2'b00);
    case (state)
      IDLE: begin
        if (start) begin
          if (!MemRead && !MemWrite) begin
            nextState = DONE;
          end else if ((MemRead && MemWrite) || size == SZ_ILLEGAL) begin
            nextState = DONE;
            nextErr   = ERR_ILLEGAL;
          end else if (misaligned) begin
            nextState = DONE;
            nextErr   = ERR_MISALIGN;
          end else begin
            nextState = ACCESS;
          end
        end
      end
      ACCESS: begin
        if (memAck) begin
          nextState = DONE;
        end else if (waitCnt == LAST_WAIT) begin
          nextState = DONE;
          nextErr   = ERR_TIMEOUT;
        end
      end
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Command latch, wait counter, MDR and completion code.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ALUOut   <= '0;
      opRead   <= 1'b0;
      opWrite  <= 1'b0;
      loadUns  <= 1'b0;
      sizeR    <= '0;
      sdR      <= '0;
      waitCnt  <= '0;
      readData <= '0;
      errCode  <= '0;
    end else begin
      if (state == IDLE && start) begin
        ALUOut  <= ALUResult;
        opRead  <= MemRead;
        opWrite <= MemWrite;
        loadUns <= unsignedLoad;
        sizeR   <= size;
        sdR     <= storeData;
      end
      if (state == ACCESS) waitCnt <= waitCnt + 1'b1;
      else                 waitCnt <= '0;
      if (state == ACCESS && memAck && opRead) readData <= loadValue;
      if (state != DONE && nextState == DONE) errCode <= nextErr;
    end
  end

  // Bus and status outputs derive from the state so reset removes them at once.
  always_comb begin
    memReq   = (state == ACCESS);
    memWE    = memReq && opWrite;
    memBE    = memReq ? laneEnable(sizeR, ALUOut[1:0]) : '0;
    memAddr  = {ALUOut[31:2], 2'b00};
    memWData = storeLanes(sizeR, sdR);
    done     = (state == DONE);
    busy     = (state != IDLE);
  end

endmodule

// File: tb/tb_memory_access.sv
module tb_memory_access;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset, start, MemRead, MemWrite, unsignedLoad, memAck;
  logic [1:0]  size;
  logic [31:0] ALUResult, storeData, memRData;
  logic        memReq, memWE, done, busy;
  logic [31:0] memAddr, memWData, readData, ALUOut;
  logic [3:0]  memBE;
  logic [1:0]  errCode;

  memory_access #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .MemRead(MemRead), .MemWrite(MemWrite),
    .size(size), .unsignedLoad(unsignedLoad), .ALUResult(ALUResult), .storeData(storeData),
    .memReq(memReq), .memWE(memWE), .memAddr(memAddr), .memBE(memBE), .memWData(memWData),
    .memAck(memAck), .memRData(memRData), .readData(readData), .ALUOut(ALUOut),
    .done(done), .busy(busy), .errCode(errCode)
  );

  always #5 clk = ~clk;

  int nVec = 0;
  int nErr = 0;

  // expected per-cycle outputs and architectural state held by the model
  logic        chkEn = 1'b0;
  logic        eBusy, eDone, eReq, eWE;
  logic [1:0]  eErr;
  logic [31:0] eAddr, eWData, mReadData, mAluOut;
  logic [3:0]  eBE;

  // observations of the most recent transaction
  int          reqCnt, doneAt;
  logic [3:0]  lastBE;
  logic [31:0] lastWData;
  logic        lastWE;
  logic [1:0]  lastErr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] expBE(input logic [1:0] sz, input logic [31:0] a);
    int base;
    base = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 3 : 15;
    if (sz == 2'd2) return 4'd15;
    return 4'(base << (a % 4));
  endfunction

  function automatic logic [31:0] expWData(input logic [1:0] sz, input logic [31:0] sd);
    if (sz == 2'd0) return (sd % 256) * 32'h01010101;
    if (sz == 2'd1) return (sd % 65536) * 32'h00010001;
    return sd;
  endfunction

  function automatic logic [31:0] expLoad(input logic [31:0] w, input logic [31:0] a,
                                          input logic [1:0] sz, input bit uns);
    logic [31:0] v;
    v = w >> (8 * (a % 4));
    if (sz == 2'd0) begin
      v = v % 256;
      if (!uns && v >= 128) v = v - 256;
    end else if (sz == 2'd1) begin
      v = v % 65536;
      if (!uns && v >= 32768) v = v - 65536;
    end
    return v;
  endfunction

  // Compare every cycle against the model's expectations.
  always @(negedge clk) begin
    if (chkEn) begin
      chk("busy", 32'(busy), 32'(eBusy));
      chk("done", 32'(done), 32'(eDone));
      chk("memReq", 32'(memReq), 32'(eReq));
      chk("readData", readData, mReadData);
      chk("ALUOut", ALUOut, mAluOut);
      if (eDone) chk("errCode", 32'(errCode), 32'(eErr));
      if (eReq) begin
        chk("memAddr", memAddr, eAddr);
        chk("memBE", 32'(memBE), 32'(eBE));
        chk("memWE", 32'(memWE), 32'(eWE));
        chk("memWData", memWData, eWData);
      end
    end
  end

  task automatic setIdle();
    eBusy = 1'b0; eDone = 1'b0; eReq = 1'b0;
  endtask

  // One command; waits = cycles without ack before ack (>= TO means never).
  // glitch raises start during ACCESS and memAck in IDLE/DONE; both must be ignored.
  task automatic runTxn(input bit rd, input bit wr, input logic [1:0] sz, input bit uns,
                        input logic [31:0] addr, input logic [31:0] sd,
                        input logic [31:0] rdata, input int waits, input bit glitch);
    int  err, nAcc;
    bit  isMem;
    isMem = 1'b0;
    if (!rd && !wr)                                 err = 0;
    else if ((rd && wr) || sz == 2'd3)              err = 2;
    else if ((sz == 2'd1 && addr % 2 != 0) ||
             (sz == 2'd2 && addr % 4 != 0))         err = 1;
    else begin
      isMem = 1'b1;
      err   = (waits >= TO) ? 3 : 0;
    end
    nAcc = !isMem ? 0 : (waits >= TO) ? TO : waits + 1;
    reqCnt = 0; doneAt = -1; lastBE = '0; lastWData = '0; lastWE = 1'b0; lastErr = '0;

    @(posedge clk); #1;
    start = 1'b1; MemRead = rd; MemWrite = wr; size = sz; unsignedLoad = uns;
    ALUResult = addr; storeData = sd; memRData = rdata; memAck = glitch;
    setIdle();
    for (int k = 1; k <= nAcc + 1; k++) begin
      @(posedge clk); #1;
      start = glitch && k == 1 && nAcc > 0;
      if (glitch) begin
        ALUResult = ~addr; storeData = ~sd;
      end
      memAck = (isMem && k == waits + 1 && k <= nAcc) || (glitch && k == nAcc + 1);
      if (k == 1) mAluOut = addr;
      if (k <= nAcc) begin
        eBusy = 1'b1; eDone = 1'b0; eReq = 1'b1;
        eAddr = addr - (addr % 4); eBE = expBE(sz, addr); eWE = wr;
        eWData = expWData(sz, sd);
      end else begin
        eBusy = 1'b1; eDone = 1'b1; eReq = 1'b0; eErr = 2'(err);
        if (isMem && rd && err == 0) mReadData = expLoad(rdata, addr, sz, uns);
      end
      if (memReq) reqCnt++;
      if (k == 1 && memReq) begin
        lastBE = memBE; lastWData = memWData; lastWE = memWE;
      end
      if (done && doneAt < 0) begin
        doneAt = k; lastErr = errCode;
      end
    end
    start = 1'b0; memAck = 1'b0;
  endtask

  initial begin
    int sawDone;
    reset = 1'b1; start = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; size = '0;
    unsignedLoad = 1'b0; ALUResult = '0; storeData = '0; memRData = '0; memAck = 1'b0;
    setIdle(); eErr = '0; eAddr = '0; eBE = '0; eWE = 1'b0; eWData = '0;
    mReadData = '0; mAluOut = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_memReq", 32'(memReq), 32'd0);
    chk("rst_memBE", 32'(memBE), 32'd0);
    chk("rst_memWE", 32'(memWE), 32'd0);
    chk("rst_errCode", 32'(errCode), 32'd0);
    chk("rst_readData", readData, 32'd0);
    chk("rst_ALUOut", ALUOut, 32'd0);
    reset = 1'b0;
    chkEn = 1'b1;

    // lw, zero-wait
    runTxn(1, 0, 2'd2, 0, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0);
    chk("lw_readData", readData, 32'hDEADBEEF);
    chk("lw_memBE", 32'(lastBE), 32'hF);
    chk("lw_doneAt", 32'(doneAt), 32'd2);
    chk("lw_err", 32'(lastErr), 32'd0);
    // lb / lbu on the top lane
    runTxn(1, 0, 2'd0, 0, 32'h103, 32'h0, 32'h80000000, 0, 0);
    chk("lb_readData", readData, 32'hFFFFFF80);
    chk("lb_memBE", 32'(lastBE), 32'h8);
    runTxn(1, 0, 2'd0, 1, 32'h103, 32'h0, 32'h80000000, 1, 0);
    chk("lbu_readData", readData, 32'h00000080);
    // sh with three wait cycles
    runTxn(0, 1, 2'd1, 0, 32'h102, 32'h1234ABCD, 32'h0, 3, 0);
    chk("sh_memBE", 32'(lastBE), 32'hC);
    chk("sh_memWData", lastWData, 32'hABCDABCD);
    chk("sh_memWE", 32'(lastWE), 32'd1);
    chk("sh_doneAt", 32'(doneAt), 32'd5);
    chk("sh_readData", readData, 32'h00000080);
    // error paths
    runTxn(1, 0, 2'd2, 0, 32'h101, 32'h0, 32'h0, 0, 0);
    chk("mis_err", 32'(lastErr), 32'd1);
    chk("mis_reqCnt", 32'(reqCnt), 32'd0);
    chk("mis_doneAt", 32'(doneAt), 32'd1);
    runTxn(1, 1, 2'd2, 0, 32'h100, 32'h0, 32'h0, 0, 0);
    chk("rw_err", 32'(lastErr), 32'd2);
    runTxn(1, 0, 2'd3, 0, 32'h100, 32'h0, 32'h0, 0, 0);
    chk("sz11_err", 32'(lastErr), 32'd2);
    runTxn(0, 0, 2'd2, 0, 32'h0000CAFE, 32'h0, 32'h0, 0, 0);
    chk("pass_err", 32'(lastErr), 32'd0);
    chk("pass_ALUOut", ALUOut, 32'h0000CAFE);
    // timeout
    runTxn(1, 0, 2'd2, 0, 32'h200, 32'h0, 32'h11111111, 99, 0);
    chk("to_reqCnt", 32'(reqCnt), 32'd4);
    chk("to_err", 32'(lastErr), 32'd3);
    chk("to_readData", readData, 32'h00000080);
    // ignored start/ack, halfword lanes, byte store, word store
    runTxn(1, 0, 2'd1, 0, 32'h206, 32'h0, 32'h80017FFF, 1, 1);
    chk("lh_readData", readData, 32'hFFFF8001);
    runTxn(1, 0, 2'd1, 1, 32'h204, 32'h0, 32'h1234F00D, 2, 0);
    chk("lhu_readData", readData, 32'h0000F00D);
    runTxn(0, 1, 2'd0, 0, 32'h101, 32'h000000A5, 32'h0, 0, 1);
    chk("sb_memBE", 32'(lastBE), 32'h2);
    chk("sb_memWData", lastWData, 32'hA5A5A5A5);
    runTxn(0, 1, 2'd2, 0, 32'h0, 32'hCAFEF00D, 32'h0, 2, 0);
    chk("sw_memWData", lastWData, 32'hCAFEF00D);

    // reset in the middle of ACCESS
    @(posedge clk); #1;
    start = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; size = 2'd2; ALUResult = 32'h300;
    storeData = 32'h0; setIdle();
    @(posedge clk); #1;
    start = 1'b0; mAluOut = 32'h300;
    eBusy = 1'b1; eReq = 1'b1; eAddr = 32'h300; eBE = 4'hF; eWE = 1'b0; eWData = 32'h0;
    @(posedge clk); #3;
    chkEn = 1'b0;
    reset = 1'b1;
    #1;
    chk("mid_memReq", 32'(memReq), 32'd0);
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_memBE", 32'(memBE), 32'd0);
    chk("mid_ALUOut", ALUOut, 32'd0);
    chk("mid_readData", readData, 32'd0);
    mReadData = '0; mAluOut = '0; setIdle();
    @(posedge clk); #1;
    reset = 1'b0;
    chkEn = 1'b1;
    sawDone = 0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      if (done) sawDone = 1;
    end
    chk("mid_noDone", 32'(sawDone), 32'd0);
    runTxn(1, 0, 2'd2, 0, 32'h300, 32'h0, 32'h5A5A1234, 1, 0);
    chk("post_readData", readData, 32'h5A5A1234);
    chk("post_doneAt", 32'(doneAt), 32'd3);

    @(posedge clk); #1;
    chkEn = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
